// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
// master: pipeline datapath side; slave: hazard_ctrl side.
interface hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       LoadE;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       PCSrcE;
  logic       MulStartE;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       StallE;
  logic       FlushE;
  logic       FlushM;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MulDoneE;
  logic       MulBusy;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output LoadE, RegWriteM, RegWriteW, PCSrcE, MulStartE,
    input  StallF, StallD, FlushD, StallE, FlushE, FlushM,
    input  ForwardAE, ForwardBE, MulDoneE, MulBusy
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  LoadE, RegWriteM, RegWriteW, PCSrcE, MulStartE,
    output StallF, StallD, FlushD, StallE, FlushE, FlushM,
    output ForwardAE, ForwardBE, MulDoneE, MulBusy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage hazard controller: forwarding, load-use, multi-cycle sequencing
// Optional stall/flush performance counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              nrst,
  hazard_ctrl_if.slave      hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic mc_idle;
  logic mc_stall;
  logic lw_match;
  logic lw_stall;

  // M-stage result is younger than W, so it wins when both match.
  always_comb begin
    hz.ForwardAE = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
      hz.ForwardAE = 2'b01;
  end

  always_comb begin
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
      hz.ForwardBE = 2'b01;
  end

  assign mc_idle  = (state_q == IDLE) && !hz.MulStartE;
  assign mc_stall = ((state_q == IDLE) && hz.MulStartE) || (state_q == BUSY);
  assign lw_match = (hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D);
  assign lw_stall = hz.LoadE && (hz.RdE != 5'd0) && lw_match && !hz.PCSrcE && mc_idle;

  // Gated by nrst so every control drops the instant reset asserts.
  assign hz.StallF   = nrst & (lw_stall | mc_stall);
  assign hz.StallD   = nrst & (lw_stall | mc_stall);
  assign hz.StallE   = nrst & mc_stall;
  assign hz.FlushM   = nrst & mc_stall;
  assign hz.FlushD   = nrst & mc_idle & hz.PCSrcE;
  assign hz.FlushE   = nrst & mc_idle & (hz.PCSrcE | lw_stall);
  assign hz.MulDoneE = done_q;
  assign hz.MulBusy  = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz.MulStartE) begin
          cnt_d   = CNT_W'(MUL_LAT - 2);
          state_d = (MUL_LAT == 2) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.StallF)
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (hz.FlushD | hz.FlushE)
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (MUL_LAT=4 main, MUL_LAT=2 shadow)
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();
  hazard_ctrl_if hif2();

  assign hif2.Rs1D      = hif.Rs1D;
  assign hif2.Rs2D      = hif.Rs2D;
  assign hif2.Rs1E      = hif.Rs1E;
  assign hif2.Rs2E      = hif.Rs2E;
  assign hif2.RdE       = hif.RdE;
  assign hif2.RdM       = hif.RdM;
  assign hif2.RdW       = hif.RdW;
  assign hif2.LoadE     = hif.LoadE;
  assign hif2.RegWriteM = hif.RegWriteM;
  assign hif2.RegWriteW = hif.RegWriteW;
  assign hif2.PCSrcE    = hif.PCSrcE;
  assign hif2.MulStartE = hif.MulStartE;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(4), .PERF_W(32)) dut (
    .clk(clk), .nrst(nrst), .hz(hif)
`ifdef HAZ_PERF_CNT_EN
    , .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
`endif
  );

  hazard_ctrl #(.MUL_LAT(2), .CNT_W(4), .PERF_W(32)) dut2 (
    .clk(clk), .nrst(nrst), .hz(hif2)
`ifdef HAZ_PERF_CNT_EN
    , .StallCnt(stall_cnt2), .FlushCnt(flush_cnt2)
`endif
  );

  typedef struct packed {
    logic       sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    logic       done, busy;
    logic       chk2, s2, d2;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  task automatic chk(input int id, input string name, input int act, input int expv);
    n_assert++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0d expected %0d", id, name, act, expv);
    end
  endtask

  // Monitor: compares the oldest expectation against the DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      chk(id, "StallF",    int'(hif.StallF),    int'(e.sf));
      chk(id, "StallD",    int'(hif.StallD),    int'(e.sd));
      chk(id, "StallE",    int'(hif.StallE),    int'(e.se));
      chk(id, "FlushD",    int'(hif.FlushD),    int'(e.fd));
      chk(id, "FlushE",    int'(hif.FlushE),    int'(e.fe));
      chk(id, "FlushM",    int'(hif.FlushM),    int'(e.fm));
      chk(id, "ForwardAE", int'(hif.ForwardAE), int'(e.fa));
      chk(id, "ForwardBE", int'(hif.ForwardBE), int'(e.fb));
      chk(id, "MulDoneE",  int'(hif.MulDoneE),  int'(e.done));
      chk(id, "MulBusy",   int'(hif.MulBusy),   int'(e.busy));
      if (e.chk2) begin
        chk(id, "lat2_StallF",   int'(hif2.StallF),   int'(e.s2));
        chk(id, "lat2_MulDoneE", int'(hif2.MulDoneE), int'(e.d2));
      end
    end
  end

  function automatic exp_t mk(input logic sf, sd, se, fd, fe, fm,
                               input logic [1:0] fa, fb, input logic done, busy);
    exp_t e;
    e = '0;
    e.sf = sf; e.sd = sd; e.se = se; e.fd = fd; e.fe = fe; e.fm = fm;
    e.fa = fa; e.fb = fb; e.done = done; e.busy = busy;
    return e;
  endfunction

  function automatic exp_t with2(input exp_t e, input logic s2, d2);
    exp_t r;
    r = e;
    r.chk2 = 1'b1; r.s2 = s2; r.d2 = d2;
    return r;
  endfunction

  task automatic push(input exp_t e);
    step_id++;
    exp_q.push_back(e);
    id_q.push_back(step_id);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
    hif.RdE  = '0; hif.RdM  = '0; hif.RdW  = '0;
    hif.LoadE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.PCSrcE = 1'b0; hif.MulStartE = 1'b0;
  endtask

  exp_t Z, MS0, MS1, MD, LW;

  initial begin
    Z   = mk(0,0,0,0,0,0,2'b00,2'b00,0,0);
    MS0 = mk(1,1,1,0,0,1,2'b00,2'b00,0,0);
    MS1 = mk(1,1,1,0,0,1,2'b00,2'b00,0,1);
    MD  = mk(0,0,0,0,0,0,2'b00,2'b00,1,1);
    LW  = mk(1,1,0,0,1,0,2'b00,2'b00,0,0);
    clr_in();
    nrst = 1'b0;

    tick(); push(Z);
    tick(); nrst = 1'b1; push(Z);

    // Forwarding
    tick(); hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1;
    hif.Rs1E = 5; hif.Rs2E = 5;      push(mk(0,0,0,0,0,0,2'b10,2'b10,0,0));
    tick(); hif.RdM = 0;             push(mk(0,0,0,0,0,0,2'b01,2'b01,0,0));
    tick(); hif.RdM = 5; hif.RegWriteM = 0;
                                     push(mk(0,0,0,0,0,0,2'b01,2'b01,0,0));
    tick(); hif.Rs2E = 0; hif.RdW = 0; push(Z);
    tick(); hif.RegWriteM = 1; hif.Rs2E = 3; hif.RdW = 3;
                                     push(mk(0,0,0,0,0,0,2'b10,2'b01,0,0));
    tick(); clr_in();                push(Z);

    // Load-use, then taken branch overriding it, then rd=x0
    tick(); hif.LoadE = 1; hif.RdE = 7; hif.Rs2D = 7; push(LW);
    tick(); hif.PCSrcE = 1;          push(mk(0,0,0,1,1,0,2'b00,2'b00,0,0));
    tick(); hif.PCSrcE = 0; hif.RdE = 0; hif.Rs2D = 0; push(Z);

    // Multi-cycle with a pending load-use hazard; MUL_LAT=2 shadow alongside
    tick(); hif.LoadE = 1; hif.RdE = 7; hif.Rs2D = 7; hif.MulStartE = 1;
                                     push(with2(MS0, 1, 0));
    tick();                          push(with2(MS1, 0, 1));
    tick();                          push(with2(MS1, 1, 0));
    tick();                          push(with2(MD,  0, 1));
    tick(); hif.MulStartE = 0;       push(with2(LW,  1, 0));
    tick(); clr_in();                push(with2(Z,   0, 0));

    // Back-to-back multi-cycle ops
    tick(); hif.MulStartE = 1;       push(MS0);
    tick();                          push(MS1);
    tick();                          push(MS1);
    tick();                          push(MD);
    tick();                          push(MS0);
    tick();                          push(MS1);
    tick();                          push(MS1);
    tick();                          push(MD);
    tick(); hif.MulStartE = 0;       push(Z);

    // Reset while BUSY, then a fresh full op
    tick(); hif.MulStartE = 1;       push(MS0);
    tick();                          push(MS1);
    tick(); nrst = 1'b0;             push(Z);
    tick(); nrst = 1'b1;             push(MS0);
    tick();                          push(MS1);
    tick();                          push(MS1);
    tick();                          push(MD);
    tick(); hif.MulStartE = 0;       push(Z);

    // Counter scenario: one load-use stall plus one multi-cycle op
    tick(); nrst = 1'b0;             push(Z);
    tick(); nrst = 1'b1; hif.LoadE = 1; hif.RdE = 7; hif.Rs1D = 7; push(LW);
    tick(); clr_in(); hif.MulStartE = 1; push(MS0);
    tick();                          push(MS1);
    tick();                          push(MS1);
    tick();                          push(MD);
    tick(); hif.MulStartE = 0;       push(Z);
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk); #1;
    chk(step_id, "StallCnt", int'(stall_cnt), 4);
    chk(step_id, "FlushCnt", int'(flush_cnt), 1);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RV32I pipeline.
- Generates stall and flush controls for the F/D, D/E and E/M pipeline registers, and forwarding selects for the Execute operand muxes.
- Sequences multi-cycle Execute operations (iterative multiplier) with a small FSM and down-counter that freezes the front of the pipe and injects bubbles into Memory.
- Sits beside the datapath; its only sequential state is the multi-cycle FSM and the optional performance counters.

Parameters:
- MUL_LAT, 4: total Execute-stage cycles of a multi-cycle op; legal range 2..16.
- CNT_W, 4: width of the multi-cycle down-counter; must hold MUL_LAT-2.
- PERF_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- Rs1D  in  5  rs1 field of the instruction in Decode.
- Rs2D  in  5  rs2 field of the instruction in Decode.
- Rs1E  in  5  rs1 of the instruction in Execute.
- Rs2E  in  5  rs2 of the instruction in Execute.
- RdE  in  5  rd of the instruction in Execute.
- RdM  in  5  rd of the instruction in Memory.
- RdW  in  5  rd of the instruction in Writeback.
- LoadE  in  1  instruction in Execute is a load.
- RegWriteM  in  1  Memory-stage instruction writes the register file.
- RegWriteW  in  1  Writeback-stage instruction writes the register file.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- MulStartE  in  1  Execute holds a multi-cycle op; held high while that instruction stays in E.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register (drives its dis).
- FlushD  out  1  clear F/D register (drives its clr).
- StallE  out  1  hold D/E register.
- FlushE  out  1  clear D/E register.
- FlushM  out  1  clear E/M register (bubble).
- ForwardAE  out  2  operand A select: 00 regfile, 01 ResultW, 10 ALUResultM.
- ForwardBE  out  2  operand B select, same encoding.
- MulDoneE  out  1  one-cycle pulse: multi-cycle result valid, instruction advances.
- MulBusy  out  1  FSM not IDLE.

Behaviour:
- Reset (nrst=0, async): FSM=IDLE, counter=0, optional counters=0. All stall/flush outputs and MulDoneE=0; Forward*=00 (combinational on inputs).
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - ForwardBE uses Rs2E with identical rules. M always has priority over W.
- Load-use: lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE && mcIdle, where mcIdle = (state==IDLE && !MulStartE).
- Branch (state IDLE, MulStartE=0): FlushD=PCSrcE, FlushE=PCSrcE|lwStall, StallF=StallD=lwStall. A taken branch overrides a simultaneous load-use hazard (no stall, both flushes).
- Multi-cycle FSM, states IDLE, BUSY, DONE:
  - IDLE & MulStartE: assert StallF, StallD, StallE, FlushM this cycle; counter<=MUL_LAT-2; next state = DONE if MUL_LAT==2, else BUSY.
  - BUSY: assert the same four; counter decrements; when counter==1, next state = DONE.
  - DONE: no stall; MulDoneE=1; next state IDLE. MulStartE is ignored in DONE.
  - Net effect: stall asserted for exactly MUL_LAT-1 consecutive cycles starting the cycle MulStartE is first seen; MulDoneE in cycle MUL_LAT.
  - Back-to-back multi-cycle ops: IDLE immediately re-triggers on the next instruction's MulStartE.
- While BUSY, or IDLE with MulStartE: FlushD=FlushE=0, lwStall suppressed. PCSrcE cannot coincide, since E holds the multi-cycle op.
- Reset mid-operation: FSM returns to IDLE and all stalls release asynchronously.
- MulBusy = (state != IDLE).

Optional Feature:
- Macro HAZ_PERF_CNT_EN. When defined, adds outputs StallCnt[PERF_W] and FlushCnt[PERF_W].
  - StallCnt increments each cycle StallF=1.
  - FlushCnt increments each cycle FlushD|FlushE = 1.
  - Both wrap at 2^PERF_W and reset to 0.
- When undefined: ports and registers are absent; all other behaviour is identical.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
- Load-use: LoadE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=1, FlushE=1, FlushD=0 for one cycle. Same with PCSrcE=1 -> StallF=0, FlushD=FlushE=1.
- Multi-cycle, MUL_LAT=4: MulStartE held high -> StallF/D/E=FlushM=1 for exactly 3 cycles, MulDoneE=1 in the 4th, then IDLE. Repeat with MUL_LAT=2 -> 1 stall cycle.
- Back-to-back multi-cycle ops: second MulStartE the cycle after MulDoneE -> second 3-cycle stall window with no gap cycle beyond DONE.
- Reset mid-operation: drop nrst in BUSY -> stalls deassert immediately; MulBusy=0; after release, a new MulStartE gives a full 3-cycle stall.
- HAZ_PERF_CNT_EN defined: one load-use stall plus one MUL_LAT=4 op -> StallCnt=4, FlushCnt=1.
